// File: rtl/clk_div_arbiter.sv
// Round-robin owner of a shared clock divider; divisor changes only on clk_out rising edges.
// Optional forced release after TIMEOUT_PERIODS when CLK_DIV_ARB_TIMEOUT_EN is defined.
module clk_div_arbiter #(
  parameter int N_REQ           = 4,
  parameter int DIV_W           = 32,
  parameter int DEFAULT_DIV     = 1000,
  parameter int MIN_PERIODS     = 4,
  parameter int TIMEOUT_PERIODS = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DIV_W-1:0] div_req,
  input  logic                   clk_out,
  output logic [DIV_W-1:0]       clk_div,
  output logic [N_REQ-1:0]       grant,
  output logic                   switch_pulse,
  output logic                   timeout_flag
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [DIV_W-1:0] DEF   = DIV_W'(DEFAULT_DIV);
  localparam logic [15:0]      MIN_C = 16'(MIN_PERIODS);

  if (N_REQ < 2 || TIMEOUT_PERIODS < 1) begin : g_param_chk
    $error("clk_div_arbiter: N_REQ must be >= 2 and TIMEOUT_PERIODS >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_OWNED,
    S_DRAIN
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     own, own_n;
  logic [IW-1:0]     rr_ptr, rr_n;
  logic [IW-1:0]     pick;
  logic [DIV_W-1:0]  div_lat, lat_n;
  logic [DIV_W-1:0]  div_sel;
  logic [DIV_W-1:0]  div_n;
  logic [N_REQ-1:0]  grant_n;
  logic [15:0]       period_cnt, cnt_n;
  logic              clk_out_d;
  logic              edge_det;
  logic              req_own;
  logic              tmo_hit;
  logic              sp_n, tf_n;

  assign edge_det = clk_out & ~clk_out_d;
  assign req_own  = req[own];
  assign div_sel  = div_req[pick*DIV_W +: DIV_W];

`ifdef CLK_DIV_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_C = 16'(TIMEOUT_PERIODS);
  assign tmo_hit = req_own && (period_cnt >= TMO_C);
`else
  assign tmo_hit = 1'b0;
`endif

  // first requester at or after rr_ptr, wrapping
  always_comb begin : rr_pick
    int   idx;
    logic found;
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    own_n   = own;
    lat_n   = div_lat;
    rr_n    = rr_ptr;
    cnt_n   = period_cnt;
    div_n   = clk_div;
    grant_n = grant;
    sp_n    = 1'b0;
    tf_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|req) begin
          own_n   = pick;
          lat_n   = (div_sel < DIV_W'(2)) ? DIV_W'(2) : div_sel;
          state_n = S_SYNC;
        end
      end
      S_SYNC: begin
        if (!req_own) begin
          state_n = S_IDLE;
        end else if (edge_det) begin
          div_n        = div_lat;
          grant_n      = '0;
          grant_n[own] = 1'b1;
          sp_n         = 1'b1;
          cnt_n        = '0;
          rr_n         = (own == IW'(N_REQ-1)) ? '0 : own + 1'b1;
          state_n      = S_OWNED;
        end
      end
      S_OWNED: begin
        if (edge_det && period_cnt != 16'hFFFF) begin
          cnt_n = period_cnt + 16'd1;
        end
        if (!req_own && period_cnt >= MIN_C) begin
          state_n = S_DRAIN;
        end else if (tmo_hit) begin
          state_n = S_DRAIN;
          tf_n    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (edge_det) begin
          div_n   = DEF;
          grant_n = '0;
          sp_n    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      own          <= '0;
      rr_ptr       <= '0;
      div_lat      <= DEF;
      period_cnt   <= '0;
      clk_out_d    <= 1'b1;
      clk_div      <= DEF;
      grant        <= '0;
      switch_pulse <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_n;
      own          <= own_n;
      rr_ptr       <= rr_n;
      div_lat      <= lat_n;
      period_cnt   <= cnt_n;
      clk_out_d    <= clk_out;
      clk_div      <= div_n;
      grant        <= grant_n;
      switch_pulse <= sp_n;
      timeout_flag <= tf_n;
    end
  end

endmodule

// File: tb/tb_clk_div_arbiter.sv
// Bench for clk_div_arbiter: directed edges on clk_out, random request sessions,
// reference owner/divisor/release-edge computed from the arbitration rules.
module tb_clk_div_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int DEF  = 10;
  localparam int MINP = 4;
  localparam int TMO  = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] div_req;
  logic            clk_out;
  logic [DW-1:0]   clk_div;
  logic [N-1:0]    grant;
  logic            switch_pulse;
  logic            timeout_flag;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] mask;
  int unsigned  divs [N];
  int           rr_m;

  clk_div_arbiter #(
    .N_REQ(N), .DIV_W(DW), .DEFAULT_DIV(DEF),
    .MIN_PERIODS(MINP), .TIMEOUT_PERIODS(TMO)
  ) dut (
    .clk_in(clk), .rst_n(rst_n), .req(req), .div_req(div_req),
    .clk_out(clk_out), .clk_div(clk_div), .grant(grant),
    .switch_pulse(switch_pulse), .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic drive();
    req = mask;
    for (int i = 0; i < N; i++) div_req[i*DW +: DW] = divs[i];
  endtask

  task automatic rand_divs();
    for (int i = 0; i < N; i++) divs[i] = $urandom_range(0, 40);
  endtask

  // low for 2-3 cycles, then rise; returns just after the edge-cycle clock
  task automatic pulse_edge();
    clk_out = 1'b0;
    repeat ($urandom_range(2, 3)) tick();
    clk_out = 1'b1;
    tick();
  endtask

  function automatic int pick_rr(input logic [N-1:0] m, input int rr);
    for (int k = 0; k < N; k++)
      if (m[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic int unsigned clamp(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction

  initial begin
    int          win;
    int          kdrop;
    int          rel;
    logic [N-1:0] oh;

    rst_n = 1'b0; clk_out = 1'b0; req = '0; div_req = '0;
    mask = '0; rr_m = 0;
    for (int i = 0; i < N; i++) divs[i] = 0;
    repeat (3) tick();
    check("rst_clk_div", clk_div, DEF);
    check("rst_grant", grant, 0);
    check("rst_pulse", switch_pulse, 0);
    check("rst_tflag", timeout_flag, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // request withdrawn in the very cycle its edge arrives
    mask = 4'b0010; divs[1] = 7; drive();
    tick();
    mask = '0; drive(); clk_out = 1'b1;
    tick();
    check("abort_grant", grant, 0);
    check("abort_pulse", switch_pulse, 0);
    repeat (2) begin
      pulse_edge();
      check("abort_idle", grant, 0);
      check("abort_div", clk_div, DEF);
    end

    // random sessions
    for (int s = 0; s < 30; s++) begin
      if (mask == '0) begin
        mask = 4'($urandom_range(1, 15));
        rand_divs();
        if ($urandom_range(0, 3) == 0) divs[$urandom_range(0, N-1)] = $urandom_range(0, 1);
        drive();
      end
      win = pick_rr(mask, rr_m);
      oh  = 4'b0001 << win;
      tick();
      check("sync_nogrant", grant, 0);
      check("sync_default", clk_div, DEF);
      pulse_edge();
      check("grant_onehot", grant, oh);
      check("grant_div", clk_div, clamp(divs[win]));
      check("grant_pulse", switch_pulse, 1);
      rr_m = (win + 1) % N;
      if ($urandom_range(0, 2) == 0) begin
        mask = mask | (4'($urandom_range(0, 15)) & ~oh);
        drive();
      end
      tick();
      check("pulse_width", switch_pulse, 0);
      kdrop = $urandom_range(1, 6);
      for (int e = 1; e <= kdrop; e++) begin
        pulse_edge();
        rand_divs(); drive();
        check("held_grant", grant, oh);
        check("held_div_ignored", switch_pulse, 0);
      end
      mask[win] = 1'b0;
      if ($urandom_range(0, 1) == 0) mask = mask | (4'($urandom_range(0, 15)) & ~oh);
      drive();
      rel = ((kdrop > MINP) ? kdrop : MINP) + 1;
      for (int e = kdrop + 1; e <= rel; e++) begin
        pulse_edge();
        if (e < rel) begin
          check("min_hold", grant, oh);
        end else begin
          check("release_grant", grant, 0);
          check("release_div", clk_div, DEF);
          check("release_pulse", switch_pulse, 1);
        end
      end
      if (mask == '0) begin
        pulse_edge();
        check("idle_grant", grant, 0);
      end
    end

    // lone requester holding on indefinitely
    mask = 4'b1000; rand_divs(); drive();
    tick();
    pulse_edge();
    check("hold_grant", grant, 4'b1000);
    rr_m = 0;
    for (int e = 1; e <= TMO + 4; e++) begin
      pulse_edge();
`ifdef CLK_DIV_ARB_TIMEOUT_EN
      if (e <= TMO) check("tmo_before", grant, 4'b1000);
      if (e == TMO) begin
        tick();
        check("tmo_flag_on", timeout_flag, 1);
        tick();
        check("tmo_flag_off", timeout_flag, 0);
        check("tmo_drain_grant", grant, 4'b1000);
      end
      if (e == TMO + 1) begin
        check("tmo_release", grant, 0);
        check("tmo_release_div", clk_div, DEF);
      end
      if (e >= TMO + 2) check("tmo_regrant", grant, 4'b1000);
`else
      check("hold_forever", grant, 4'b1000);
      check("no_tflag", timeout_flag, 0);
`endif
    end

    // asynchronous reset while owned
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_div", clk_div, DEF);
    check("async_rst_pulse", switch_pulse, 0);
    mask = 4'b1010; rand_divs(); drive();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulse_edge();
    check("post_rst_grant", grant, 4'b0010);
    check("post_rst_div", clk_div, clamp(divs[1]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
